sort_result_serializer: RTL

//  Downstream stage of the 4-input Sort block. Detects Sort's done rising edge,

---
 rtl/sort_pkg.sv | 16 +
 rtl/sort_result_serializer_if.sv | 24 ++
 rtl/sort_result_serializer_rise_detect.sv | 24 ++
 rtl/sort_result_serializer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the Sort result serializer slice: lane count,
// index width and the serializer state encoding.
package sort_pkg;

    localparam int SORT_LANES = 4;
    localparam int IDX_W      = $clog2(SORT_LANES);

    // Index of the final word of a stream (carries out_last).
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SORT_LANES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/sort_result_serializer_if.sv
// Output stream of the Sort result serializer: one signed word per
// valid/ready transfer, with last marking the fourth word.
interface sort_result_serializer_if #(
    parameter int N = 3
);
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/sort_result_serializer_rise_detect.sv
// 1-bit rising-edge detector. The previous input value is registered and
// cleared by the synchronous reset, so a level already high when reset
// releases is reported as a rise on the first cycle out of reset.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q_r;

    // Remember last cycle's input level.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q_r <= 1'b0;
        end else begin
            d_q_r <= d;
        end
    end

    assign rise = d & ~d_q_r;

endmodule

// File: rtl/sort_result_serializer.sv
// Sort result serializer: on a rising edge of Sort's done, snapshot the four
// sorted words and stream them smallest first over valid/ready, with last on
// the fourth word. Sort may be re-run while the private snapshot drains; a
// done rise while a stream is still pending is dropped and flagged (overrun).
// Optional feature macro: SORT_CHECK_EN adds a sticky signed-order check of
// each captured set (order_err); without it order_err is tied low.
module sort_result_serializer
    import sort_pkg::*;
#(
    parameter int N = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 done,
    input  logic [N-1:0]         s0,
    input  logic [N-1:0]         s1,
    input  logic [N-1:0]         s2,
    input  logic [N-1:0]         s3,
    sort_result_serializer_if.master stream,
    output logic                 busy,
    output logic                 overrun,
    output logic                 order_err
);

    state_t           state_r;
    logic [IDX_W-1:0] idx_r;
    logic [N-1:0]     snap_r [SORT_LANES];
    logic [N-1:0]     data_r;
    logic             valid_r;
    logic             last_r;
    logic             busy_r;
    logic             overrun_r;
    logic             done_rise_s;
    logic [IDX_W-1:0] next_idx_s;

    rise_detect u_done_rise (
        .clk  (clk),
        .rst  (rst),
        .d    (done),
        .rise (done_rise_s)
    );

    assign next_idx_s = idx_r + IDX_W'(1);

    // Serializer FSM: capture on done rise, then walk the snapshot one word
    // per accepted transfer; all stream outputs are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            idx_r     <= {IDX_W{1'b0}};
            data_r    <= {N{1'b0}};
            valid_r   <= 1'b0;
            last_r    <= 1'b0;
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
            for (int i = 0; i < SORT_LANES; i++) begin
                snap_r[i] <= {N{1'b0}};
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (done_rise_s) begin
                        snap_r[0] <= s0;
                        snap_r[1] <= s1;
                        snap_r[2] <= s2;
                        snap_r[3] <= s3;
                        idx_r     <= {IDX_W{1'b0}};
                        data_r    <= s0;
                        valid_r   <= 1'b1;
                        last_r    <= 1'b0;
                        busy_r    <= 1'b1;
                        state_r   <= SEND;
                    end else begin
                        valid_r <= 1'b0;
                        last_r  <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                SEND: begin
                    // A new result while this one drains is dropped, even
                    // on the cycle of the final transfer.
                    if (done_rise_s) begin
                        overrun_r <= 1'b1;
                    end else begin
                        overrun_r <= overrun_r;
                    end
                    if (valid_r && stream.out_ready) begin
                        if (idx_r == LAST_IDX) begin
                            idx_r   <= {IDX_W{1'b0}};
                            data_r  <= {N{1'b0}};
                            valid_r <= 1'b0;
                            last_r  <= 1'b0;
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            idx_r  <= next_idx_s;
                            data_r <= snap_r[next_idx_s];
                            last_r <= (next_idx_s == LAST_IDX);
                        end
                    end else begin
                        // Stalled: hold the presented word and last flag.
                        data_r <= data_r;
                        last_r <= last_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    idx_r   <= {IDX_W{1'b0}};
                    valid_r <= 1'b0;
                    last_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign stream.out_data  = data_r;
    assign stream.out_valid = valid_r;
    assign stream.out_last  = last_r;
    assign busy             = busy_r;
    assign overrun          = overrun_r;

`ifdef SORT_CHECK_EN
    logic order_err_r;

    // True when the four lanes are non-decreasing as signed values.
    function automatic logic lanes_ordered(
        input logic [N-1:0] a,
        input logic [N-1:0] b,
        input logic [N-1:0] c,
        input logic [N-1:0] d
    );
        return ($signed(a) <= $signed(b)) &&
               ($signed(b) <= $signed(c)) &&
               ($signed(c) <= $signed(d));
    endfunction

    // Sticky flag for a captured set that is not in ascending signed order;
    // checked on the incoming words at the capture edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            order_err_r <= 1'b0;
        end else if ((state_r == IDLE) && done_rise_s &&
                     !lanes_ordered(s0, s1, s2, s3)) begin
            order_err_r <= 1'b1;
        end else begin
            order_err_r <= order_err_r;
        end
    end

    assign order_err = order_err_r;
`else
    assign order_err = 1'b0;
`endif

endmodule
